rv32i_fetch: RTL and testbench

RV32I_FETCH -- requirements
Module: rv32i_fetch

---
 rtl/rv32i_fetch.sv | 140 ++++++++++++++
 tb/tb_rv32i_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: one outstanding memory request, stall hold and redirect/flush.
// Define RV32I_FETCH_SKID_EN to capture an instruction acked under stall in a 1-entry skid.
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_change_pc,
    input  logic [31:0] i_new_pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;
    logic        acc;

`ifdef RV32I_FETCH_SKID_EN
    logic        skid_vld;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
`endif

    // An ack only counts against a live strobe.
    assign acc = o_stb_inst && i_ack_inst;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_FETCH;
            pc         <= PC_RESET;
            o_stb_inst <= 1'b0;
            o_ce       <= 1'b0;
            o_inst     <= '0;
            o_pc       <= '0;
            discard    <= 1'b0;
`ifdef RV32I_FETCH_SKID_EN
            skid_vld   <= 1'b0;
`endif
        end else if (i_change_pc) begin
            pc    <= i_new_pc;
            o_ce  <= 1'b0;
            state <= S_FETCH;
`ifdef RV32I_FETCH_SKID_EN
            skid_vld <= 1'b0;
`endif
            // A request still in flight keeps its strobe until acked, then its data is dropped.
            if (o_stb_inst && !i_ack_inst) begin
                discard <= 1'b1;
            end else begin
                discard    <= 1'b0;
                o_stb_inst <= 1'b1;
                o_iaddr    <= i_new_pc;
            end
        end else if (discard) begin
            o_ce <= 1'b0;
            if (acc) begin
                discard <= 1'b0;
                o_iaddr <= pc;
            end
        end else if (i_flush) begin
            o_ce  <= 1'b0;
            state <= S_FETCH;
`ifdef RV32I_FETCH_SKID_EN
            skid_vld <= 1'b0;
`endif
            if (!(o_stb_inst && !i_ack_inst)) begin
                o_stb_inst <= 1'b1;
                o_iaddr    <= pc;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (acc && !i_stall) begin
                        o_inst  <= i_inst;
                        o_pc    <= pc;
                        o_ce    <= 1'b1;
                        pc      <= pc + 32'd4;
                        o_iaddr <= pc + 32'd4;
                    end else if (acc) begin
                        o_stb_inst <= 1'b0;
`ifdef RV32I_FETCH_SKID_EN
                        skid_vld  <= 1'b1;
                        skid_inst <= i_inst;
                        skid_pc   <= pc;
                        pc        <= pc + 32'd4;
                        state     <= S_HOLD;
`else
                        state     <= S_WAIT;
`endif
                    end else begin
                        o_stb_inst <= 1'b1;
                        o_iaddr    <= pc;
                        if (!i_stall) begin
                            o_ce <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
`ifdef RV32I_FETCH_SKID_EN
                        o_inst   <= skid_inst;
                        o_pc     <= skid_pc;
                        o_ce     <= skid_vld;
                        skid_vld <= 1'b0;
`else
                        o_ce     <= 1'b0;
`endif
                        state      <= S_FETCH;
                        o_stb_inst <= 1'b1;
                        o_iaddr    <= pc;
                    end
                end
                default: begin
                    // WAIT: the instruction acked under stall was dropped; re-request it.
                    if (!i_stall) begin
                        o_ce       <= 1'b0;
                        state      <= S_FETCH;
                        o_stb_inst <= 1'b1;
                        o_iaddr    <= pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios plus a randomized run against a stream model.
module tb_rv32i_fetch;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
`ifdef RV32I_FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_ce;
    logic        i_stall;
    logic        i_flush;
    logic        i_change_pc;
    logic [31:0] i_new_pc;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int stale_cnt = 0;
    int stale_done = 0;
    logic [31:0] acked_q[$];

    rv32i_fetch #(.PC_RESET(PC_RST)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_iaddr(o_iaddr), .o_stb_inst(o_stb_inst),
        .i_ack_inst(i_ack_inst), .i_inst(i_inst), .o_inst(o_inst), .o_pc(o_pc), .o_ce(o_ce),
        .i_stall(i_stall), .i_flush(i_flush), .i_change_pc(i_change_pc), .i_new_pc(i_new_pc)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Instruction memory: acks a strobe in its lat-th cycle; records every accepted ack address.
    initial begin
        int cnt;
        logic stb_seen;
        logic [31:0] addr_seen;
        cnt = 0; stb_seen = 1'b0; addr_seen = '0;
        i_ack_inst = 1'b0; i_inst = '0;
        forever begin
            @(posedge i_clk);
            if (i_ack_inst && stb_seen) begin
                acked_q.push_back(addr_seen);
                cnt = 0;
            end else if (stb_seen) begin
                cnt++;
            end else begin
                cnt = 0;
            end
            #1;
            stb_seen  = o_stb_inst;
            addr_seen = o_iaddr;
            if (stale_cnt != stale_done) begin
                stale_done = stale_cnt;
                i_ack_inst = 1'b1;
                i_inst     = 32'hDEAD_BEEF;
            end else if (!i_rst_n) begin
                i_ack_inst = 1'b0;
                cnt = 0;
            end else if (o_stb_inst && (cnt + 1 >= lat)) begin
                i_ack_inst = 1'b1;
                i_inst     = memf(o_iaddr);
            end else begin
                i_ack_inst = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic do_reset(input int l);
        lat = l;
        i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_change_pc = 1'b0;
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        lat = 1;
        i_rst_n = 1'b0;
        tick(); tick();
        checks++; if (o_stb_inst !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", o_stb_inst); end
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", o_ce); end
        checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", o_inst); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", o_pc); end
        i_rst_n = 1'b1;
        tick();
        checks++; if (o_stb_inst !== 1'b1 || o_iaddr !== PC_RST) begin
            errors++; $display("FAIL first_strobe got stb=%b addr=%h want 1/%h", o_stb_inst, o_iaddr, PC_RST); end
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL first_ce got %b want 0", o_ce); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_ce !== 1'b1 || o_pc !== PC_RST + 32'(4 * k)) begin
                errors++; $display("FAIL seq_pc%0d got ce=%b pc=%h want 1/%h", k, o_ce, o_pc, PC_RST + 32'(4 * k)); end
            checks++; if (o_inst !== memf(PC_RST + 32'(4 * k))) begin
                errors++; $display("FAIL seq_inst%0d got %h want %h", k, o_inst, memf(PC_RST + 32'(4 * k))); end
            checks++; if (o_iaddr !== PC_RST + 32'(4 * (k + 1))) begin
                errors++; $display("FAIL seq_iaddr%0d got %h want %h", k, o_iaddr, PC_RST + 32'(4 * (k + 1))); end
        end
    endtask

    task automatic test_stall();
        logic        h_ce;
        logic [31:0] h_pc, h_inst;
        int base, n10;
        do_reset(1);
        base = acked_q.size();
        for (int i = 0; i < 20; i++) begin
            if (o_stb_inst === 1'b1 && o_iaddr === 32'h10 && i_ack_inst === 1'b1) break;
            tick();
        end
        checks++; if (o_iaddr !== 32'h10 || o_pc !== 32'hC || o_ce !== 1'b1) begin
            errors++; $display("FAIL stall_setup got addr=%h pc=%h ce=%b want 10/c/1", o_iaddr, o_pc, o_ce); end
        h_ce = o_ce; h_pc = o_pc; h_inst = o_inst;
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_ce !== h_ce || o_pc !== h_pc || o_inst !== h_inst) begin
                errors++; $display("FAIL stall_hold%0d got ce=%b pc=%h inst=%h want %b/%h/%h", i, o_ce, o_pc, o_inst, h_ce, h_pc, h_inst); end
            checks++; if (o_stb_inst !== 1'b0) begin errors++; $display("FAIL stall_stb%0d got %b want 0", i, o_stb_inst); end
        end
        i_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_ce === 1'b1) break;
        end
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h10 || o_inst !== memf(32'h10)) begin
            errors++; $display("FAIL stall_issue got ce=%b pc=%h inst=%h want 1/10/%h", o_ce, o_pc, o_inst, memf(32'h10)); end
        n10 = 0;
        for (int i = base; i < acked_q.size(); i++) if (acked_q[i] == 32'h10) n10++;
        checks++; if (n10 != (SKID ? 1 : 2)) begin
            errors++; $display("FAIL stall_fetches_0x10 got %0d want %0d", n10, SKID ? 1 : 2); end
        tick();
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h14) begin
            errors++; $display("FAIL stall_next got ce=%b pc=%h want 1/14", o_ce, o_pc); end
    endtask

    task automatic test_redirect_pending();
        int base, n14;
        do_reset(3);
        base = acked_q.size();
        for (int i = 0; i < 40; i++) begin
            if (o_stb_inst === 1'b1 && o_iaddr === 32'h14 && i_ack_inst === 1'b0) break;
            tick();
        end
        checks++; if (o_iaddr !== 32'h14 || i_ack_inst !== 1'b0) begin
            errors++; $display("FAIL redir_setup got addr=%h ack=%b want 14/0", o_iaddr, i_ack_inst); end
        i_change_pc = 1'b1; i_new_pc = 32'h200;
        tick();
        i_change_pc = 1'b0;
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b want 0", o_ce); end
        checks++; if (o_stb_inst !== 1'b1 || o_iaddr !== 32'h14) begin
            errors++; $display("FAIL redir_keep_req got stb=%b addr=%h want 1/14", o_stb_inst, o_iaddr); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_ce === 1'b1) break;
        end
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h200 || o_inst !== memf(32'h200)) begin
            errors++; $display("FAIL redir_target got ce=%b pc=%h inst=%h want 1/200/%h", o_ce, o_pc, o_inst, memf(32'h200)); end
        n14 = 0;
        for (int i = base; i < acked_q.size(); i++) if (acked_q[i] == 32'h14) n14++;
        checks++; if (n14 != 1) begin errors++; $display("FAIL redir_old_acked got %0d want 1", n14); end
    endtask

    task automatic test_redirect_same();
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            if (o_iaddr === 32'h8 && i_ack_inst === 1'b1) break;
            tick();
        end
        i_change_pc = 1'b1; i_new_pc = 32'h300;
        tick();
        i_change_pc = 1'b0;
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL same_bubble got %b want 0", o_ce); end
        checks++; if (o_stb_inst !== 1'b1 || o_iaddr !== 32'h300) begin
            errors++; $display("FAIL same_strobe got stb=%b addr=%h want 1/300", o_stb_inst, o_iaddr); end
        tick();
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h300 || o_inst !== memf(32'h300)) begin
            errors++; $display("FAIL same_target got ce=%b pc=%h inst=%h want 1/300/%h", o_ce, o_pc, o_inst, memf(32'h300)); end
    endtask

    task automatic test_latency();
        logic [31:0] exp, p_addr;
        logic p_stb, p_ack;
        int run, ndel;
        do_reset(4);
        exp = PC_RST; run = 0; ndel = 0; p_stb = 1'b0; p_ack = 1'b0; p_addr = '0;
        for (int c = 0; c < 40; c++) begin
            if (p_stb && !p_ack) begin
                checks++; if (o_stb_inst !== 1'b1 || o_iaddr !== p_addr) begin
                    errors++; $display("FAIL lat_stable got stb=%b addr=%h want 1/%h", o_stb_inst, o_iaddr, p_addr); end
            end
            if (o_stb_inst === 1'b1) run++;
            if (o_stb_inst === 1'b1 && i_ack_inst === 1'b1) begin
                checks++; if (run != 4) begin errors++; $display("FAIL lat_strobe_len got %0d want 4", run); end
                run = 0;
            end
            if (o_ce === 1'b1) begin
                checks++; if (o_pc !== exp || o_inst !== memf(exp)) begin
                    errors++; $display("FAIL lat_deliver got pc=%h inst=%h want %h/%h", o_pc, o_inst, exp, memf(exp)); end
                exp += 32'd4; ndel++;
            end
            p_stb = o_stb_inst; p_ack = i_ack_inst; p_addr = o_iaddr;
            tick();
        end
        checks++; if (ndel < 8 || ndel > 10) begin errors++; $display("FAIL lat_count got %0d want 8..10", ndel); end
    endtask

    task automatic test_reset_mid();
        do_reset(4);
        for (int i = 0; i < 30; i++) begin
            if (o_stb_inst === 1'b1 && o_iaddr === 32'h8 && i_ack_inst === 1'b0) break;
            tick();
        end
        i_rst_n = 1'b0;
        tick();
        checks++; if (o_stb_inst !== 1'b0 || o_ce !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle got stb=%b ce=%b want 0/0", o_stb_inst, o_ce); end
        stale_cnt++;
        tick();
        i_rst_n = 1'b1;
        tick();
        checks++; if (o_stb_inst !== 1'b1 || o_iaddr !== PC_RST || o_ce !== 1'b0) begin
            errors++; $display("FAIL rstmid_restart got stb=%b addr=%h ce=%b want 1/%h/0", o_stb_inst, o_iaddr, o_ce, PC_RST); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_ce === 1'b1) break;
        end
        checks++; if (o_ce !== 1'b1 || o_pc !== PC_RST || o_inst !== memf(PC_RST)) begin
            errors++; $display("FAIL rstmid_first got ce=%b pc=%h inst=%h want 1/%h/%h", o_ce, o_pc, o_inst, PC_RST, memf(PC_RST)); end
    endtask

    task automatic test_flush();
        logic [31:0] want;
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            if (o_ce === 1'b1 && o_pc === 32'h8) break;
            tick();
        end
        i_stall = 1'b1;
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL flush_kill got %b want 0", o_ce); end
        tick();
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL flush_stay got %b want 0", o_ce); end
        i_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_ce === 1'b1) break;
        end
        want = SKID ? 32'h10 : 32'hC;
        checks++; if (o_ce !== 1'b1 || o_pc !== want || o_inst !== memf(want)) begin
            errors++; $display("FAIL flush_resume got ce=%b pc=%h inst=%h want 1/%h/%h", o_ce, o_pc, o_inst, want, memf(want)); end
    endtask

    // Stream model: consumed instructions are sequential words from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, h_pc, h_inst, p_addr;
        logic h_ce, have_hold, exp_bubble, p_stb, p_ack, chg;
        int idle;
        do_reset(1);
        exp_pc = PC_RST; have_hold = 1'b0; exp_bubble = 1'b0; p_stb = 1'b0; p_ack = 1'b0;
        p_addr = '0; h_ce = 1'b0; h_pc = '0; h_inst = '0; idle = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 0) lat = int'($urandom_range(1, 4));
            if (have_hold) begin
                checks++; if (o_ce !== h_ce || o_pc !== h_pc || o_inst !== h_inst) begin
                    errors++; $display("FAIL rnd_hold c=%0d got ce=%b pc=%h want %b/%h", c, o_ce, o_pc, h_ce, h_pc); end
            end
            if (exp_bubble) begin
                checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rnd_bubble c=%0d got %b want 0", c, o_ce); end
            end
            if (p_stb && !p_ack) begin
                checks++; if (o_stb_inst !== 1'b1 || o_iaddr !== p_addr) begin
                    errors++; $display("FAIL rnd_stable c=%0d got stb=%b addr=%h want 1/%h", c, o_stb_inst, o_iaddr, p_addr); end
            end
            i_stall = ($urandom_range(0, 99) < 30);
            chg = ($urandom_range(0, 99) < 4);
            i_change_pc = chg;
            i_flush = chg && ($urandom_range(0, 1) == 1);
            i_new_pc = $urandom & 32'h0000_0FFC;
            if (o_ce === 1'b1 && !i_stall) begin
                checks++; if (o_pc !== exp_pc || o_inst !== memf(exp_pc)) begin
                    errors++; $display("FAIL rnd_stream c=%0d got pc=%h inst=%h want %h/%h", c, o_pc, o_inst, exp_pc, memf(exp_pc)); end
                exp_pc += 32'd4;
                idle = 0;
            end else begin
                idle++;
            end
            if (chg) exp_pc = i_new_pc;
            have_hold = i_stall && !chg;
            exp_bubble = chg;
            h_ce = o_ce; h_pc = o_pc; h_inst = o_inst;
            p_stb = o_stb_inst; p_ack = i_ack_inst; p_addr = o_iaddr;
            if (idle > 80) begin
                checks++; errors++;
                $display("FAIL rnd_progress c=%0d got no delivery for %0d cycles want <=80", c, idle);
                break;
            end
            tick();
        end
        i_stall = 1'b0; i_change_pc = 1'b0; i_flush = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_change_pc = 1'b0; i_new_pc = '0;
        test_reset();
        test_stall();
        test_redirect_pending();
        test_redirect_same();
        test_latency();
        test_reset_mid();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
